phys_dbus_responder: RTL and testbench
======================================

// Module: phys_dbus_responder
// PURPOSE
//  Memory-side responder for the CPU data bus after virtual-to-physical translation.
//  Accepts one physical-address request at a time and serves it from an on-chip
//  scratchpad RAM or from a small MMIO register window. Returns read data after a
//  fixed, parameterised latency.
//  Used as the bench/SoC endpoint for the translated dbus.
// PARAMETERS
//  RAM_AW     12              log2 of RAM size in bytes; RAM occupies paddr [0, 2^RAM_AW)
//  LATENCY    2               cycles from accept to data_ok; legal range 1..15
//  MMIO_BASE  32'h1FAF_0000   base of the 16-byte MMIO window; bits [3:0] must be 0
// PORTS
//  clk           in   1   clock, rising edge
//  resetn        in   1   asynchronous active-low reset
//  req_valid     in   1   request present; addr/strobe/data held stable until addr_ok
//  req_addr      in   32  physical byte address; bits [1:0] ignored (word access)
//  req_strobe    in   4   byte write enables; 4'h0 = read
//  req_data      in   32  write data, lane-aligned
//  resp_addr_ok  out  1   request accepted this cycle
//  resp_data_ok  out  1   one-cycle pulse: request complete, resp_data valid
//  resp_data     out  32  read data; 0 for writes
// BEHAVIOUR
//  Reset (asynchronous, resetn=0):
//   - state=IDLE; resp_addr_ok=0, resp_data_ok=0, resp_data=0.
//   - cycle counter=0, scratch=0, err=0. RAM contents are not reset.
//   - An in-flight request is dropped; no data_ok is issued for it.
//  FSM IDLE -> BUSY -> RESP -> IDLE:
//   - IDLE: resp_addr_ok = req_valid (combinational). Accept edge = IDLE && req_valid.
//     On the accept edge: go to BUSY with cnt=LATENCY-1, or go straight to RESP if LATENCY==1.
//   - BUSY: cnt decrements each cycle; go to RESP when cnt==1.
//   - RESP: resp_data_ok=1 for exactly this cycle, then IDLE. resp_addr_ok=0 outside IDLE.
//  Timing:
//   - Accept in cycle T gives data_ok in cycle T+LATENCY.
//   - Earliest next accept is cycle T+LATENCY+1.
//  Access semantics, all performed on the accept edge:
//   - Writes commit on the accept edge, per byte lane where strobe[i]=1.
//   - Read data is sampled on the accept edge into a holding register and driven on
//     resp_data in the RESP cycle; resp_data=0 in every other cycle.
//   - A read accepted after a completed write returns the new data.
//  Address decode:
//   - RAM hit: req_addr[31:RAM_AW]==0. Word index = req_addr[RAM_AW-1:2].
//   - MMIO hit: req_addr[31:4]==MMIO_BASE[31:4]. Offsets:
//     - 0x0 CYCLES: read-only, free-running +1 per clock after reset, wraps at 2^32.
//       Read returns its value in the accept cycle. Writes are ignored.
//     - 0x4 SCRATCH: read/write, honours byte strobes.
//     - 0x8 ERR: bit0 sticky decode-error flag; upper bits read 0.
//       A write with strobe[0]=1 and data[0]=1 clears bit0.
//     - 0xC: reads 0; writes ignored; not an error.
//  Decode error (no hit):
//   - Read returns 32'hDEAD_BEEF; write is dropped.
//   - ERR.bit0 is set on the accept edge. Set has priority over a clear on the same edge.
//  The request still completes with normal timing; the bus never hangs.
//  Protocol violations:
//   - req_* changing while req_valid=1 before acceptance is illegal (assertion in bench).
//   - req_valid may drop at any time while BUSY/RESP with no effect.
// TESTING
//  1 Reset: hold resetn=0, release, idle 1 cycle -> all outputs 0.
//    Read MMIO_BASE+0x0 -> small nonzero CYCLES value; a second read returns a larger value.
//  2 Write 0x100 = 32'h1234_5678 (strobe 4'hF), then read 0x100.
//    With LATENCY=2 and accept at T -> data_ok only at T+2; resp_data=32'h1234_5678.
//  3 Write 0x100 strobe 4'h2 data 32'h0000_AB00, then read 0x100 -> 32'h1234_AB78.
//  4 Read 32'h8000_0000 -> 32'hDEAD_BEEF and ERR reads 1.
//    Write ERR=1 with strobe 4'h1 -> ERR reads 0.
//  5 Hold req_valid=1 for 8 cycles with LATENCY=2.
//    -> addr_ok at cycles 0, 3, 6 only; exactly one data_ok per accept.
//  6 Pull resetn low in the BUSY cycle after accepting a read.
//    -> no data_ok follows; after release, a read of SCRATCH returns 0 with normal timing.

Source files
------------

// File: rtl/phys_dbus_responder.sv
// Memory-side responder for the translated CPU data bus: one request at a time,
// served from a word-organised scratchpad RAM or a 16-byte MMIO window.
module phys_dbus_responder #(
    parameter int          RAM_AW    = 12,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] MMIO_BASE = 32'h1FAF_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_strobe,
    input  logic [31:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [31:0] resp_data
);

    localparam int WORDS = 1 << (RAM_AW - 2);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic [31:0]        cycles_q;
    logic [31:0]        scratch_q;
    logic               err_q;
    logic [31:0]        hold_q;
    logic               dataOk_q;
    logic [31:0]        respData_q;
    logic [31:0]        mem [WORDS];

    logic               accept;
    logic               isWrite;
    logic               ramHit;
    logic               mmioHit;
    logic               decodeErr;
    logic               scratchWr;
    logic               errClr;
    logic [RAM_AW-3:0]  wordIdx;
    logic [31:0]        read_d;
    logic [31:0]        scratch_d;
    logic               unused_ok;

    assign resp_addr_ok = (state_q == IDLE) && req_valid;
    assign accept       = resp_addr_ok;
    assign isWrite      = |req_strobe;
    assign ramHit       = (req_addr[31:RAM_AW] == '0);
    assign mmioHit      = (req_addr[31:4] == MMIO_BASE[31:4]);
    assign decodeErr    = !ramHit && !mmioHit;
    assign wordIdx      = req_addr[RAM_AW-1:2];
    assign scratchWr    = accept && isWrite && mmioHit && (req_addr[3:2] == 2'd1);
    assign errClr       = accept && mmioHit && (req_addr[3:2] == 2'd2)
                          && req_strobe[0] && req_data[0];
    assign unused_ok    = ^req_addr[1:0];

    assign resp_data_ok = dataOk_q;
    assign resp_data    = respData_q;

    // Read value captured at the accept edge; writes always respond with zero.
    always_comb begin
        read_d    = '0;
        scratch_d = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (req_strobe[i]) scratch_d[8*i +: 8] = req_data[8*i +: 8];
        end
        if (isWrite) begin
            read_d = '0;
        end else if (ramHit) begin
            read_d = mem[wordIdx];
        end else if (mmioHit) begin
            case (req_addr[3:2])
                2'd0:    read_d = cycles_q;
                2'd1:    read_d = scratch_q;
                2'd2:    read_d = {31'd0, err_q};
                default: read_d = '0;
            endcase
        end else begin
            read_d = 32'hDEAD_BEEF;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cycles_q   <= '0;
            scratch_q  <= '0;
            err_q      <= 1'b0;
            hold_q     <= '0;
            dataOk_q   <= 1'b0;
            respData_q <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        hold_q <= read_d;
                        if (LATENCY == 1) begin
                            state_q    <= RESP;
                            dataOk_q   <= 1'b1;
                            respData_q <= read_d;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd1) begin
                        state_q    <= RESP;
                        dataOk_q   <= 1'b1;
                        respData_q <= hold_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    dataOk_q   <= 1'b0;
                    respData_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
            if (scratchWr) scratch_q <= scratch_d;
            // A decode error always wins over a clear landing on the same edge.
            if (accept && decodeErr) err_q <= 1'b1;
            else if (errClr)         err_q <= 1'b0;
        end
    end

    // RAM contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (accept && isWrite && ramHit) begin
            for (int i = 0; i < 4; i++) begin
                if (req_strobe[i]) mem[wordIdx][8*i +: 8] <= req_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_phys_dbus_responder.sv
// Self-checking bench for phys_dbus_responder: directed scenarios followed by
// randomized traffic compared against a byte-level reference model.
module tb_phys_dbus_responder;

    localparam int          RAM_AW    = 12;
    localparam int          LATENCY   = 2;
    localparam logic [31:0] MMIO_BASE = 32'h1FAF_0000;
    localparam longint      RAM_BYTES = 64'd1 << RAM_AW;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_strobe;
    logic [31:0] req_data;
    logic        resp_addr_ok;
    logic        resp_data_ok;
    logic [31:0] resp_data;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  ramBytes [int unsigned];
    logic [31:0] modelScratch;
    logic        modelErr;
    int          edgesSinceReset = 0;
    logic [31:0] lastData;

    phys_dbus_responder #(
        .RAM_AW   (RAM_AW),
        .LATENCY  (LATENCY),
        .MMIO_BASE(MMIO_BASE)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_strobe  (req_strobe),
        .req_data    (req_data),
        .resp_addr_ok(resp_addr_ok),
        .resp_data_ok(resp_data_ok),
        .resp_data   (resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgesSinceReset++;

    // Request fields must stay put while a request waits for acceptance.
    logic        pendValid = 1'b0;
    logic [31:0] pendAddr, pendData;
    logic [3:0]  pendStrobe;
    always @(posedge clk) begin
        if (resetn && pendValid && req_valid) begin
            assert (req_addr == pendAddr && req_strobe == pendStrobe && req_data == pendData)
                else $error("[TB] request changed before acceptance");
        end
        pendValid  = req_valid && !resp_addr_ok;
        pendAddr   = req_addr;
        pendStrobe = req_strobe;
        pendData   = req_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        modelScratch = '0;
        modelErr     = 1'b0;
    endtask

    task automatic modelAccess(input logic [31:0] addr, input logic [3:0] strb,
                               input logic [31:0] wdata, output logic [31:0] rdata);
        logic [31:0] wa;
        wa    = {addr[31:2], 2'b00};
        rdata = '0;
        if (longint'(wa) < RAM_BYTES) begin
            for (int i = 0; i < 4; i++) begin
                if (strb == 4'h0)  rdata[8*i +: 8] = ramBytes[wa + i];
                else if (strb[i])  ramBytes[wa + i] = wdata[8*i +: 8];
            end
        end else if ((wa >> 4) == (MMIO_BASE >> 4)) begin
            case (wa[3:0])
                4'h0: if (strb == 4'h0) rdata = 32'(edgesSinceReset);
                4'h4: begin
                    for (int i = 0; i < 4; i++) begin
                        if (strb == 4'h0)  rdata[8*i +: 8] = modelScratch[8*i +: 8];
                        else if (strb[i])  modelScratch[8*i +: 8] = wdata[8*i +: 8];
                    end
                end
                4'h8: begin
                    if (strb == 4'h0)               rdata = {31'd0, modelErr};
                    else if (strb[0] && wdata[0])   modelErr = 1'b0;
                end
                default: ;
            endcase
        end else begin
            if (strb == 4'h0) rdata = 32'hDEAD_BEEF;
            modelErr = 1'b1;
        end
    endtask

    // One complete transaction: present, accept, then wait (bounded) for data_ok.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] strb,
                                 input logic [31:0] wdata, input string tag);
        logic [31:0] exp;
        bit          seen;
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_strobe = strb;
        req_data   = wdata;
        #1;
        checkOutput({tag, "/addr_ok"}, {31'd0, resp_addr_ok}, 32'd1);
        modelAccess(addr, strb, wdata, exp);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        seen      = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            #1;
            if (resp_data_ok) begin
                seen     = 1'b1;
                lastData = resp_data;
                checkOutput({tag, "/latency"}, 32'(k), 32'(LATENCY));
                checkOutput({tag, "/data"}, resp_data, exp);
                checkOutput({tag, "/addr_ok_busy"}, {31'd0, resp_addr_ok}, 32'd0);
            end else begin
                checkOutput({tag, "/data_idle"}, resp_data, 32'd0);
                @(negedge clk);
            end
        end
        if (!seen) checkOutput({tag, "/timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] firstCyc;
        logic [31:0] exp;
        int          dataOkCount;
        modelReset();
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_strobe = '0;
        req_data   = '0;

        // Reset behaviour and CYCLES counter
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst/data_ok", {31'd0, resp_data_ok}, 32'd0);
        checkOutput("rst/data", resp_data, 32'd0);
        resetn          = 1'b1;
        edgesSinceReset = 0;
        @(negedge clk);
        #1;
        checkOutput("idle/addr_ok", {31'd0, resp_addr_ok}, 32'd0);
        checkOutput("idle/data_ok", {31'd0, resp_data_ok}, 32'd0);
        checkOutput("idle/data", resp_data, 32'd0);
        applyStimulus(MMIO_BASE, 4'h0, '0, "cyc1");
        firstCyc = lastData;
        checkOutput("cyc1/nonzero", {31'd0, firstCyc != 0}, 32'd1);
        applyStimulus(MMIO_BASE, 4'h0, '0, "cyc2");
        checkOutput("cyc2/grows", {31'd0, lastData > firstCyc}, 32'd1);

        // Full and partial RAM writes
        applyStimulus(32'h100, 4'hF, 32'h1234_5678, "wr_full");
        applyStimulus(32'h100, 4'h0, '0, "rd_full");
        checkOutput("rd_full/const", lastData, 32'h1234_5678);
        applyStimulus(32'h100, 4'h2, 32'h0000_AB00, "wr_lane1");
        applyStimulus(32'h103, 4'h0, '0, "rd_lane1");
        checkOutput("rd_lane1/const", lastData, 32'h1234_AB78);

        // RAM top boundary and the first address above it
        applyStimulus(32'hFFC, 4'hF, 32'hCAFE_F00D, "wr_top");
        applyStimulus(32'hFFC, 4'h0, '0, "rd_top");
        applyStimulus(32'h1000, 4'h0, '0, "rd_above");

        // Decode errors and the sticky ERR flag
        applyStimulus(32'h8000_0000, 4'h0, '0, "rd_miss");
        checkOutput("rd_miss/const", lastData, 32'hDEAD_BEEF);
        applyStimulus(MMIO_BASE + 32'h8, 4'h0, '0, "err_set");
        checkOutput("err_set/const", lastData, 32'd1);
        applyStimulus(MMIO_BASE + 32'h8, 4'h1, 32'd1, "err_wr");
        applyStimulus(MMIO_BASE + 32'h8, 4'h0, '0, "err_clr");
        checkOutput("err_clr/const", lastData, 32'd0);
        applyStimulus(MMIO_BASE + 32'h10, 4'hF, 32'h5555_5555, "wr_miss");
        applyStimulus(MMIO_BASE + 32'h8, 4'h0, '0, "err_wrmiss");
        applyStimulus(MMIO_BASE + 32'h8, 4'h1, 32'd1, "err_wr2");

        // Reserved offset, read-only CYCLES, scratch strobes
        applyStimulus(MMIO_BASE + 32'hC, 4'hF, 32'hFFFF_FFFF, "wr_resv");
        applyStimulus(MMIO_BASE + 32'hC, 4'h0, '0, "rd_resv");
        applyStimulus(MMIO_BASE, 4'hF, 32'h0, "wr_cyc");
        applyStimulus(MMIO_BASE, 4'h0, '0, "rd_cyc");
        applyStimulus(MMIO_BASE + 32'h4, 4'hF, 32'hA5A5_0F0F, "wr_scr");
        applyStimulus(MMIO_BASE + 32'h4, 4'h9, 32'h1100_0022, "wr_scr_part");
        applyStimulus(MMIO_BASE + 32'h4, 4'h0, '0, "rd_scr");
        applyStimulus(MMIO_BASE + 32'h8, 4'h0, '0, "err_clean");

        // Back-to-back: req_valid held high for 8 cycles
        @(negedge clk);
        req_valid   = 1'b1;
        req_addr    = MMIO_BASE + 32'h4;
        req_strobe  = 4'h0;
        req_data    = '0;
        dataOkCount = 0;
        modelAccess(req_addr, 4'h0, '0, exp);
        for (int c = 0; c < 8; c++) begin
            #1;
            checkOutput($sformatf("b2b/addr_ok%0d", c), {31'd0, resp_addr_ok}, {31'd0, c % 3 == 0});
            checkOutput($sformatf("b2b/data_ok%0d", c), {31'd0, resp_data_ok}, {31'd0, c % 3 == 2});
            if (resp_data_ok) begin
                dataOkCount++;
                checkOutput($sformatf("b2b/data%0d", c), resp_data, exp);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        #1;
        checkOutput("b2b/data_ok8", {31'd0, resp_data_ok}, 32'd1);
        if (resp_data_ok) dataOkCount++;
        checkOutput("b2b/count", 32'(dataOkCount), 32'd3);

        // Reset while a read is in flight
        applyStimulus(MMIO_BASE + 32'h4, 4'hF, 32'h7777_1234, "wr_scr2");
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = MMIO_BASE + 32'h4;
        req_strobe = 4'h0;
        @(negedge clk);
        req_valid = 1'b0;
        resetn    = 1'b0;
        modelReset();
        for (int c = 0; c < 6; c++) begin
            #1;
            checkOutput($sformatf("rstbusy/data_ok%0d", c), {31'd0, resp_data_ok}, 32'd0);
            if (c == 2) begin
                resetn          = 1'b1;
                edgesSinceReset = 0;
            end
            @(negedge clk);
        end
        applyStimulus(MMIO_BASE + 32'h4, 4'h0, '0, "rstbusy/scr");
        checkOutput("rstbusy/scr_const", lastData, 32'd0);
        applyStimulus(32'h100, 4'h0, '0, "ram_keep");

        // Randomized traffic over a small RAM window, the MMIO window and misses
        for (int w = 0; w < 16; w++) applyStimulus(32'h200 + 32'(4 * w), 4'hF, $urandom, "pre");
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [3:0]  s;
            int          cls;
            cls = $urandom_range(0, 9);
            if (cls <= 5)      a = 32'h200 + 32'($urandom_range(0, 63));
            else if (cls <= 7) a = MMIO_BASE + 32'($urandom_range(0, 15));
            else if (cls == 8) a = 32'h8000_0000 | 32'($urandom);
            else               a = ($urandom_range(0, 1) == 1) ? 32'hFFC : 32'h1000 + 32'($urandom_range(0, 3));
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            applyStimulus(a, s, $urandom, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
